// File: rtl/pupil_pkg.sv
// Shared widths and FSM encoding for the pupil bounding-box detector.
package pupil_pkg;

    localparam int CW = 10;
    localparam int NW = 19;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE,
        REPORT
    } state_t;

endpackage

// File: rtl/pupil_raster_cnt.sv
// Raster X/Y position of the current valid pixel; sync clear takes effect for the pixel
// presented in the same cycle. in_range_o drops once IMG_W*IMG_H pixels have been seen.
module pupil_raster_cnt
    import pupil_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          in_range_o
);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          done_q, done_d;

    always_comb begin
        x_o        = clr_i ? '0 : x_q;
        y_o        = clr_i ? '0 : y_q;
        in_range_o = clr_i ? 1'b1 : ~done_q;
        x_d        = x_o;
        y_d        = y_o;
        done_d     = ~in_range_o;
        if (adv_i && in_range_o) begin
            if (x_o == CW'(IMG_W - 1)) begin
                x_d = '0;
                // Last pixel of the frame: Y holds, everything after is out of range
                if (y_o == CW'(IMG_H - 1))
                    done_d = 1'b1;
                else
                    y_d = y_o + CW'(1);
            end else begin
                x_d = x_o + CW'(1);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/pupil_bbox_detect.sv
// Binarizes red pixels against a per-frame dark threshold and reports the dark-pixel box and count
// at frame end. Mask out 1 cycle after input; optional centre outputs under PUPIL_CENTER_EN.
module pupil_bbox_detect
    import pupil_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int DW        = 10,
    parameter int MIN_COUNT = 64
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iFVAL,
    input  logic          iDVAL,
    input  logic [DW-1:0] iDATA,
    input  logic [DW-1:0] iTHRESH,
    output logic          oBIN_DVAL,
    output logic          oBIN,
    output logic [CW-1:0] oX_MIN,
    output logic [CW-1:0] oX_MAX,
    output logic [CW-1:0] oY_MIN,
    output logic [CW-1:0] oY_MAX,
    output logic [NW-1:0] oCOUNT,
    output logic          oFOUND,
`ifdef PUPIL_CENTER_EN
    output logic [CW-1:0] oCX,
    output logic [CW-1:0] oCY,
`endif
    output logic          oBOX_VALID
);

    state_t        state_q, state_d;
    logic          fval_q;
    logic [DW-1:0] thr_q, thr_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic [CW-1:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d;
    logic [CW-1:0] by_min_q, by_min_d, by_max_q, by_max_d;

    logic          bin_q, bin_dval_q;
    logic [CW-1:0] rx_min_q, rx_max_q, ry_min_q, ry_max_q;
    logic [NW-1:0] rcnt_q;
    logic          rfound_q, rvalid_q;

    logic          pix_vld, start, acc_en, is_dark, dark_hit, rpt, found;
    logic [DW-1:0] thr_eff;
    logic [CW-1:0] x_cur, y_cur;
    logic          in_range;

    pupil_raster_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .clr_i      (start),
        .adv_i      (acc_en),
        .x_o        (x_cur),
        .y_o        (y_cur),
        .in_range_o (in_range)
    );

    always_comb begin
        pix_vld  = iFVAL & iDVAL;
        // A rise seen in REPORT restarts directly, so back-to-back frames lose nothing
        start    = iFVAL & ~fval_q & ((state_q == IDLE) | (state_q == REPORT));
        thr_eff  = start ? iTHRESH : thr_q;
        is_dark  = iDATA < thr_eff;
        acc_en   = pix_vld & (start | (state_q == ACTIVE));
        dark_hit = acc_en & in_range & is_dark;
        rpt      = (state_q == ACTIVE) & ~iFVAL;
        found    = cnt_q >= NW'(MIN_COUNT);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_IDLE: if (!iFVAL) state_d = IDLE;
            IDLE:      if (start)  state_d = ACTIVE;
            ACTIVE:    if (!iFVAL) state_d = REPORT;
            REPORT:    state_d = start ? ACTIVE : IDLE;
            default:   state_d = WAIT_IDLE;
        endcase
    end

    // Frame-start clear first, then the rise-cycle pixel accumulates on top of it
    always_comb begin
        thr_d    = thr_eff;
        cnt_d    = start ? '0   : cnt_q;
        seen_d   = start ? 1'b0 : seen_q;
        bx_min_d = start ? '0   : bx_min_q;
        bx_max_d = start ? '0   : bx_max_q;
        by_min_d = start ? '0   : by_min_q;
        by_max_d = start ? '0   : by_max_q;
        if (dark_hit) begin
            if (!(&cnt_d))
                cnt_d = cnt_d + NW'(1);
            if (!seen_d) begin
                bx_min_d = x_cur;
                bx_max_d = x_cur;
                by_min_d = y_cur;
                by_max_d = y_cur;
            end else begin
                if (x_cur < bx_min_d) bx_min_d = x_cur;
                if (x_cur > bx_max_d) bx_max_d = x_cur;
                if (y_cur < by_min_d) by_min_d = y_cur;
                if (y_cur > by_max_d) by_max_d = y_cur;
            end
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= WAIT_IDLE;
            fval_q   <= 1'b0;
            thr_q    <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            bx_min_q <= '0;
            bx_max_q <= '0;
            by_min_q <= '0;
            by_max_q <= '0;
        end else begin
            state_q  <= state_d;
            fval_q   <= iFVAL;
            thr_q    <= thr_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            bx_min_q <= bx_min_d;
            bx_max_q <= bx_max_d;
            by_min_q <= by_min_d;
            by_max_q <= by_max_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            bin_q      <= 1'b0;
            bin_dval_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rx_min_q   <= '0;
            rx_max_q   <= '0;
            ry_min_q   <= '0;
            ry_max_q   <= '0;
            rcnt_q     <= '0;
            rfound_q   <= 1'b0;
        end else begin
            bin_dval_q <= pix_vld;
            bin_q      <= pix_vld & is_dark;
            rvalid_q   <= rpt;
            if (rpt) begin
                rcnt_q   <= cnt_q;
                rfound_q <= found;
                rx_min_q <= found ? bx_min_q : '0;
                rx_max_q <= found ? bx_max_q : '0;
                ry_min_q <= found ? by_min_q : '0;
                ry_max_q <= found ? by_max_q : '0;
            end
        end
    end

`ifdef PUPIL_CENTER_EN
    logic [CW:0]   cx_sum, cy_sum;
    logic [CW-1:0] cx_q, cy_q;

    always_comb begin
        cx_sum = {1'b0, bx_min_q} + {1'b0, bx_max_q};
        cy_sum = {1'b0, by_min_q} + {1'b0, by_max_q};
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (rpt) begin
            cx_q <= found ? CW'(cx_sum >> 1) : '0;
            cy_q <= found ? CW'(cy_sum >> 1) : '0;
        end
    end

    assign oCX = cx_q;
    assign oCY = cy_q;
`endif

    assign oBIN_DVAL  = bin_dval_q;
    assign oBIN       = bin_q;
    assign oX_MIN     = rx_min_q;
    assign oX_MAX     = rx_max_q;
    assign oY_MIN     = ry_min_q;
    assign oY_MAX     = ry_max_q;
    assign oCOUNT     = rcnt_q;
    assign oFOUND     = rfound_q;
    assign oBOX_VALID = rvalid_q;

endmodule

// File: tb/tb_pupil_bbox_detect.sv
// Directed bench for pupil_bbox_detect on an 8x4 image, threshold 100, MIN_COUNT 2.
module tb_pupil_bbox_detect;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int MIN_C = 2;
    localparam int THR   = 100;

    logic        iCLK, iRST, iFVAL, iDVAL;
    logic [9:0]  iDATA, iTHRESH;
    logic        oBIN_DVAL, oBIN, oFOUND, oBOX_VALID;
    logic [9:0]  oX_MIN, oX_MAX, oY_MIN, oY_MAX;
    logic [18:0] oCOUNT;
`ifdef PUPIL_CENTER_EN
    logic [9:0]  oCX, oCY;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [9:0] pix [0:63];

    pupil_bbox_detect #(
        .IMG_W     (W),
        .IMG_H     (H),
        .DW        (10),
        .MIN_COUNT (MIN_C)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iFVAL      (iFVAL),
        .iDVAL      (iDVAL),
        .iDATA      (iDATA),
        .iTHRESH    (iTHRESH),
        .oBIN_DVAL  (oBIN_DVAL),
        .oBIN       (oBIN),
        .oX_MIN     (oX_MIN),
        .oX_MAX     (oX_MAX),
        .oY_MIN     (oY_MIN),
        .oY_MAX     (oY_MAX),
        .oCOUNT     (oCOUNT),
        .oFOUND     (oFOUND),
`ifdef PUPIL_CENTER_EN
        .oCX        (oCX),
        .oCY        (oCY),
`endif
        .oBOX_VALID (oBOX_VALID)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic fill(input logic [9:0] val);
        for (int i = 0; i < 64; i++) pix[i] = val;
    endtask

    task automatic idle(input int n);
        iFVAL = 1'b0; iDVAL = 1'b0; iDATA = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK); #1;
            check_eq("idle_box_valid", oBOX_VALID, 0);
            check_eq("idle_bin_dval", oBIN_DVAL, 0);
        end
    endtask

    // Streams n pixels from pix[] (pixel 0 in the iFVAL rise cycle), drops iFVAL and checks
    // the report one cycle later. iTHRESH changes to thr_after once the frame has started.
    task automatic run_frame(input int n, input int thr_after, input int e_cnt,
                             input int ex0, input int ex1, input int ey0, input int ey1);
        logic f;
        iTHRESH = 10'(THR);
        iFVAL = 1'b1;
        for (int i = 0; i < n; i++) begin
            iDVAL = 1'b1;
            iDATA = pix[i];
            @(posedge iCLK); #1;
            if (i == 0) begin
                check_eq("no_pulse_at_start", oBOX_VALID, 0);
                iTHRESH = 10'(thr_after);
            end
            check_eq("bin_dval", oBIN_DVAL, 1);
            check_eq($sformatf("bin[%0d]", i), oBIN, (pix[i] < 10'(THR)) ? 1 : 0);
        end
        iFVAL = 1'b0; iDVAL = 1'b0; iDATA = '0;
        @(posedge iCLK); #1;
        f = (e_cnt >= MIN_C);
        check_eq("box_valid", oBOX_VALID, 1);
        check_eq("count", oCOUNT, e_cnt);
        check_eq("found", oFOUND, f);
        check_eq("x_min", oX_MIN, f ? ex0 : 0);
        check_eq("x_max", oX_MAX, f ? ex1 : 0);
        check_eq("y_min", oY_MIN, f ? ey0 : 0);
        check_eq("y_max", oY_MAX, f ? ey1 : 0);
`ifdef PUPIL_CENTER_EN
        check_eq("cx", oCX, f ? (ex0 + ex1) / 2 : 0);
        check_eq("cy", oCY, f ? (ey0 + ey1) / 2 : 0);
`endif
    endtask

    initial begin
        int pulses;
        iRST = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0; iDATA = '0; iTHRESH = 10'(THR);
        repeat (3) @(posedge iCLK);
        #1;
        check_eq("rst_box_valid", oBOX_VALID, 0);
        check_eq("rst_count", oCOUNT, 0);
        check_eq("rst_found", oFOUND, 0);
        check_eq("rst_bin", oBIN, 0);
        check_eq("rst_x_max", oX_MAX, 0);
        iRST = 1'b1;
        idle(3);

        // 2x2 dark block at (3..4, 1..2)
        fill(10'd500);
        pix[11] = 10'd50; pix[12] = 10'd50; pix[19] = 10'd50; pix[20] = 10'd50;
        run_frame(32, THR, 4, 3, 4, 1, 2);
        idle(1);
        check_eq("box_hold_x_min", oX_MIN, 3);

        // single dark pixel at (7,3): below MIN_COUNT
        fill(10'd500);
        pix[31] = 10'd50;
        run_frame(32, THR, 1, 0, 0, 0, 0);
        idle(2);

        // threshold boundary, dark pixel in the rise cycle, mid-frame iTHRESH change ignored
        fill(10'd500);
        pix[0] = 10'd99; pix[9] = 10'd100; pix[10] = 10'd99;
        run_frame(32, 600, 2, 0, 2, 0, 1);
        idle(2);

        // 40 pixels into an 8x4 frame: pixel 35 is beyond the frame
        fill(10'd500);
        pix[2] = 10'd50; pix[3] = 10'd50; pix[35] = 10'd50;
        run_frame(40, THR, 2, 2, 3, 0, 0);
        idle(2);

        // box X 2..5, Y 1..2 (centre 3,1)
        fill(10'd500);
        pix[10] = 10'd50; pix[21] = 10'd50;
        run_frame(32, THR, 2, 2, 5, 1, 2);

        // back-to-back: iFVAL rises in the REPORT cycle
        fill(10'd500);
        pix[0] = 10'd10; pix[31] = 10'd10;
        run_frame(32, THR, 2, 0, 7, 0, 3);
        idle(2);

        // reset mid-frame, released with iFVAL still high
        fill(10'd20);
        iFVAL = 1'b1; iDVAL = 1'b1; iDATA = 10'd20;
        repeat (10) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        #1;
        check_eq("midrst_count", oCOUNT, 0);
        check_eq("midrst_bin_dval", oBIN_DVAL, 0);
        @(posedge iCLK); #1;
        iRST = 1'b1;
        repeat (12) @(posedge iCLK);
        #1;
        iFVAL = 1'b0; iDVAL = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge iCLK); #1;
            if (oBOX_VALID) pulses++;
        end
        check_eq("midrst_pulses", pulses, 0);
        check_eq("midrst_found", oFOUND, 0);
        fill(10'd500);
        pix[11] = 10'd50; pix[12] = 10'd50; pix[19] = 10'd50; pix[20] = 10'd50;
        run_frame(32, THR, 4, 3, 4, 1, 2);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pupil_bbox_detect.md
Name: pupil_bbox_detect

Overview:
- Consumes the single-channel (red) 10-bit pixel stream from the colour-select stage.
- Binarizes each pixel against a dark threshold and tracks the bounding box and count of dark (pupil) pixels per frame.
- Reports the box on each frame end for downstream iris-segmentation and overlay stages.
- Also forwards the binary mask stream with 1-cycle latency.

Parameters:
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame.
- DW, 10, pixel data width.
- MIN_COUNT, 64, minimum dark-pixel count for a valid detection.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous, active-low reset.
- iFVAL  in  1  frame valid, high for the whole frame.
- iDVAL  in  1  pixel valid; pixel counted only when iFVAL&iDVAL.
- iDATA  in  DW  red-channel pixel.
- iTHRESH  in  DW  dark threshold; latched at frame start.
- oBIN_DVAL  out  1  mask valid, iDVAL&iFVAL delayed 1 cycle.
- oBIN  out  1  1 when the pixel is dark, delayed 1 cycle.
- oX_MIN, oX_MAX  out  10  box columns.
- oY_MIN, oY_MAX  out  10  box rows.
- oCOUNT  out  19  dark-pixel count of the last frame.
- oFOUND  out  1  last frame's count >= MIN_COUNT (level).
- oBOX_VALID  out  1  1-cycle pulse when results update.

Behaviour:
- Reset: all outputs 0; FSM enters WAIT_IDLE; counters and accumulators clear; latched threshold clears to 0.
- Reset mid-frame: the partial frame is discarded; the next report comes only after a complete frame.
- FSM WAIT_IDLE: wait for iFVAL=0, which prevents reporting a partial frame after reset. Transition to IDLE.
- FSM IDLE, frame start: on iFVAL rising edge (iFVAL=1 and fval_d=0), go to ACTIVE and, in the same cycle:
  - X=Y=0;
  - clear box, count and seen-flag;
  - latch iTHRESH.
- Frame-start pixel: a pixel valid in the rise cycle is pixel (0,0), compared against the newly latched iTHRESH. Clear has priority, then that pixel is accumulated.
- FSM ACTIVE, dark test: a valid pixel is dark iff iDATA < threshold (strict, unsigned).
- Dark-pixel update:
  - count++ (saturates at all-ones);
  - first dark pixel loads min=max=(X,Y);
  - later dark pixels update min/max by unsigned compare.
- Raster counter:
  - X increments per valid pixel; at X=IMG_W-1, X wraps to 0 and Y increments.
  - Y saturates at IMG_H-1; pixels beyond IMG_W*IMG_H are ignored (no count, no box update).
- Frame end: on iFVAL falling edge, go to REPORT. iDVAL is ignored while iFVAL=0.
- FSM REPORT (1 cycle):
  - register the box and count outputs;
  - oFOUND = (count >= MIN_COUNT);
  - if not found, all four box outputs are 0;
  - oBOX_VALID=1 for exactly this cycle;
  - next state IDLE.
- Report timing: oBOX_VALID is high in the cycle after the edge that sampled iFVAL low. Box outputs hold until the next REPORT.
- Short frame (fewer pixels than IMG_W*IMG_H): reported normally with the pixels seen.
- Frame restart: an iFVAL rise in the REPORT cycle is captured; the FSM goes directly to ACTIVE after REPORT, with the rise-cycle pixel handled as above.
- Mask path: oBIN/oBIN_DVAL are registered every cycle regardless of FSM state; oBIN=0 when not valid.

Optional Feature:
- Macro: PUPIL_CENTER_EN.
- Defined: adds outputs oCX and oCY (10 bits each), registered in REPORT:
  - oCX=(oX_MIN+oX_MAX)>>1 and oCY=(oY_MIN+oY_MAX)>>1, using an 11-bit sum then a shift;
  - both 0 when not found.
- Undefined: the ports and logic are absent.

Decomposition:
- Package pupil_pkg holds:
  - the coordinate width (10);
  - the count width (19);
  - the FSM state enum (WAIT_IDLE, IDLE, ACTIVE, REPORT).
- Sub-module pupil_raster_cnt: the X/Y counter with wrap, saturation, sync clear and an in-range flag.

Test Plan:
- Tests use IMG_W=8, IMG_H=4, MIN_COUNT=2, iTHRESH=100.
- Dark 2x2 block (data=50 at (3,1),(4,1),(3,2),(4,2); all others 500) -> box X 3..4, Y 1..2, oCOUNT=4, oFOUND=1, one oBOX_VALID pulse 1 cycle after iFVAL falls.
- Single dark pixel at (7,3) -> oCOUNT=1, oFOUND=0, all box outputs 0.
- Threshold boundary: data=100 -> not dark; data=99 -> dark; oBIN follows 1 cycle after iDVAL.
- Reset asserted mid-frame, released while iFVAL=1 -> no oBOX_VALID for that frame; next full frame reports correctly.
- 40 valid pixels in an 8x4 frame, dark pixel at index 35 -> ignored; oCOUNT excludes it.
- With PUPIL_CENTER_EN, box X 2..5, Y 1..2 -> oCX=3, oCY=1.
